// File: rtl/flag_branch_unit.sv
// ============================================================================
// Module      : flag_branch_unit
// Description : Architectural {V,N,Z} flag register with a conditional-branch
//               resolver that stalls one cycle on an in-flight flag writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [2:0]  ex_flags,
  input  logic        ex_flags_set,
  input  logic [2:0]  ex_opcode,
  input  logic        ex_hold,
  input  logic        flush,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  output logic [2:0]  flags_q,
  output logic        br_stall,
  output logic        br_resolved,
  output logic        br_taken,
  output logic [15:0] stall_cnt,
  output logic [15:0] taken_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  state_t      r_state;
  logic        w_we;
  logic        w_hazard;
  logic        w_eval;
  logic        w_cond_true;
  logic [2:0]  w_flags_nxt;

  assign w_we     = ex_valid & ex_flags_set & ~ex_hold & ~flush;
  assign w_hazard = (r_state == ST_IDLE) & br_valid & ex_valid & ex_flags_set & ~flush;
  assign br_stall = rst_n & w_hazard;

  // A branch is evaluated either when leaving WAIT or straight from IDLE with no hazard.
  assign w_eval = ~flush & ((r_state == ST_WAIT) | (br_valid & ~w_hazard));

  always_comb begin
    w_flags_nxt = flags_q;
    if (w_we) begin
      case (ex_opcode)
        3'b000, 3'b001:                 w_flags_nxt = ex_flags;
        3'b010, 3'b100, 3'b101, 3'b110: w_flags_nxt = {flags_q[2:1], ex_flags[0]};
        default:                        w_flags_nxt = flags_q;
      endcase
    end
  end

  always_comb begin
    w_cond_true = 1'b0;
    case (br_cond)
      3'b000:  w_cond_true = ~flags_q[0];
      3'b001:  w_cond_true = flags_q[0];
      3'b010:  w_cond_true = ~flags_q[0] & ~flags_q[1];
      3'b011:  w_cond_true = flags_q[1];
      3'b100:  w_cond_true = flags_q[0] | ~flags_q[1];
      3'b101:  w_cond_true = flags_q[1] | flags_q[0];
      3'b110:  w_cond_true = flags_q[2];
      default: w_cond_true = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      flags_q     <= 3'b000;
      br_resolved <= 1'b0;
      br_taken    <= 1'b0;
      stall_cnt   <= 16'h0000;
      taken_cnt   <= 16'h0000;
    end else begin
      flags_q     <= w_flags_nxt;
      br_resolved <= w_eval;
      br_taken    <= w_eval & w_cond_true;

      if (br_stall && stall_cnt != C_CNT_MAX)
        stall_cnt <= stall_cnt + 16'd1;
      if (w_eval && w_cond_true && taken_cnt != C_CNT_MAX)
        taken_cnt <= taken_cnt + 16'd1;

      // A held EX writer keeps the branch stalled in IDLE until it moves on.
      case (r_state)
        ST_IDLE: r_state <= (w_hazard && !ex_hold) ? ST_WAIT : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
// ============================================================================
// Module      : tb_flag_branch_unit
// Description : Self-checking bench for flag_branch_unit with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n, ex_valid, ex_flags_set, ex_hold, flush, br_valid;
  logic [2:0]  ex_flags, ex_opcode, br_cond;
  logic [2:0]  flags_q;
  logic        br_stall, br_resolved, br_taken;
  logic [15:0] stall_cnt, taken_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit [2:0] m_flags;
  bit       m_pending;
  bit       m_res, m_taken;
  int       m_stall_cnt, m_taken_cnt;

  always #5 clk = ~clk;

  flag_branch_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_flags(ex_flags),
    .ex_flags_set(ex_flags_set), .ex_opcode(ex_opcode), .ex_hold(ex_hold),
    .flush(flush), .br_valid(br_valid), .br_cond(br_cond),
    .flags_q(flags_q), .br_stall(br_stall), .br_resolved(br_resolved),
    .br_taken(br_taken), .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  function automatic bit cond_met(input bit [2:0] c, input bit [2:0] f);
    bit v, n, z;
    v = f[2]; n = f[1]; z = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_stall();
    return rst_n && !m_pending && br_valid && ex_valid && ex_flags_set && !flush;
  endfunction

  // Advance model and DUT by one clock; outputs are settled on return.
  task automatic tick();
    bit [2:0] nf;
    bit np, nr, nt;
    int nsc, ntc;
    nf = m_flags; np = m_pending; nr = 0; nt = 0;
    nsc = m_stall_cnt; ntc = m_taken_cnt;
    if (!rst_n) begin
      nf = 0; np = 0; nsc = 0; ntc = 0;
    end else begin
      if (m_stall() && nsc < 65535) nsc++;
      if (ex_valid && ex_flags_set && !ex_hold && !flush) begin
        if (ex_opcode == 3'd0 || ex_opcode == 3'd1) nf = ex_flags;
        else if (ex_opcode != 3'd3 && ex_opcode != 3'd7) nf[0] = ex_flags[0];
      end
      if (flush) np = 0;
      else if (m_pending) begin
        nr = 1; nt = cond_met(br_cond, m_flags); np = 0;
      end else if (m_stall()) np = !ex_hold;
      else if (br_valid) begin
        nr = 1; nt = cond_met(br_cond, m_flags);
      end
      if (nt && ntc < 65535) ntc++;
    end
    @(posedge clk);
    #1;
    m_flags = nf; m_pending = np; m_res = nr; m_taken = nt;
    m_stall_cnt = nsc; m_taken_cnt = ntc;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_flags = 0; ex_flags_set = 0; ex_opcode = 0;
    ex_hold = 0; flush = 0; br_valid = 0; br_cond = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic ex_write(input bit [2:0] op, input bit [2:0] f);
    idle_inputs();
    ex_valid = 1; ex_flags_set = 1; ex_opcode = op; ex_flags = f;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0; ex_valid = 1; ex_flags_set = 1; ex_flags = 3'b111; ex_opcode = 0;
    ex_hold = 1; flush = 1; br_valid = 1; br_cond = 3'd7;
    #1;
    n_checks++;
    if (br_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", br_stall); end
    tick();
    n_checks++;
    if (flags_q !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", flags_q); end
    n_checks++;
    if (br_resolved !== 1'b0 || br_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_branch got=%b%b exp=00", br_resolved, br_taken);
    end
    n_checks++;
    if (stall_cnt !== 16'h0 || taken_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_cnts got=%h/%h exp=0000/0000", stall_cnt, taken_cnt);
    end
    rst_n = 1;
  endtask

  task automatic test_zero_flag();
    do_reset();
    ex_write(3'd1, 3'b001);
    n_checks++;
    if (flags_q !== 3'b001) begin n_fail++; $display("FAIL sub_flags got=%b exp=001", flags_q); end
    idle_inputs(); br_valid = 1; br_cond = 3'd1;
    #1;
    n_checks++;
    if (br_stall !== 1'b0) begin n_fail++; $display("FAIL beq_nostall got=%b exp=0", br_stall); end
    tick();
    n_checks++;
    if (br_resolved !== 1'b1 || br_taken !== 1'b1) begin
      n_fail++; $display("FAIL beq_taken got=%b%b exp=11", br_resolved, br_taken);
    end
    idle_inputs(); tick();
    n_checks++;
    if (taken_cnt !== 16'd1 || br_resolved !== 1'b0) begin
      n_fail++; $display("FAIL beq_cnt got=%0d res=%b exp=1 res=0", taken_cnt, br_resolved);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_valid = 1; ex_flags_set = 1; ex_opcode = 3'd1; ex_flags = 3'b001;
    br_valid = 1; br_cond = 3'd1;
    #1;
    n_checks++;
    if (br_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_T got=%b exp=1", br_stall); end
    tick();
    ex_valid = 0; ex_flags_set = 0;
    #1;
    n_checks++;
    if (br_stall !== 1'b0 || br_resolved !== 1'b0) begin
      n_fail++; $display("FAIL b2b_T1 got stall=%b res=%b exp=0 0", br_stall, br_resolved);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (br_resolved !== 1'b1 || br_taken !== 1'b1) begin
      n_fail++; $display("FAIL b2b_T2 got=%b%b exp=11", br_resolved, br_taken);
    end
    n_checks++;
    if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL b2b_stall_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_partial_and_blocked();
    do_reset();
    ex_write(3'd0, 3'b110);
    ex_write(3'd2, 3'b001);
    n_checks++;
    if (flags_q !== 3'b111) begin n_fail++; $display("FAIL partial_xor got=%b exp=111", flags_q); end
    ex_write(3'd2, 3'b110);
    n_checks++;
    if (flags_q !== 3'b110) begin n_fail++; $display("FAIL partial_clr_z got=%b exp=110", flags_q); end
    ex_write(3'd7, 3'b101);
    ex_write(3'd3, 3'b001);
    n_checks++;
    if (flags_q !== 3'b110) begin n_fail++; $display("FAIL blocked_write got=%b exp=110", flags_q); end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      ex_valid = 1; ex_flags_set = 1; ex_hold = 1; ex_opcode = 3'd0; ex_flags = 3'b100;
      br_valid = 1; br_cond = 3'd6;
      #1;
      n_checks++;
      if (br_stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, br_stall); end
      tick();
    end
    ex_hold = 0;
    tick();
    ex_valid = 0; ex_flags_set = 0;
    tick();
    idle_inputs();
    n_checks++;
    if (br_resolved !== 1'b1 || br_taken !== 1'b1 || stall_cnt !== 16'd4) begin
      n_fail++; $display("FAIL hold_resolve got=%b%b cnt=%0d exp=11 cnt=4", br_resolved, br_taken, stall_cnt);
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    ex_valid = 1; ex_flags_set = 1; ex_opcode = 3'd1; ex_flags = 3'b001;
    br_valid = 1; br_cond = 3'd7;
    tick();
    ex_valid = 0; flush = 1;
    tick();
    n_checks++;
    if (br_resolved !== 1'b0) begin n_fail++; $display("FAIL flush_wait_res got=%b exp=0", br_resolved); end
    flush = 0; ex_valid = 1; ex_flags_set = 1;
    #1;
    n_checks++;
    if (br_stall !== 1'b1) begin n_fail++; $display("FAIL flush_back_idle got=%b exp=1", br_stall); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_wait();
    do_reset();
    ex_write(3'd0, 3'b110);
    ex_write(3'd2, 3'b001);
    ex_valid = 1; ex_flags_set = 1; ex_opcode = 3'd0; ex_flags = 3'b111;
    br_valid = 1; br_cond = 3'd7;
    tick();
    ex_valid = 0; rst_n = 0;
    tick();
    n_checks++;
    if (flags_q !== 3'b000 || br_resolved !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_wait got flags=%b res=%b exp=000 0", flags_q, br_resolved);
    end
    rst_n = 1; idle_inputs();
    tick();
    n_checks++;
    if (br_resolved !== 1'b0) begin n_fail++; $display("FAIL reset_wait_drop got=%b exp=0", br_resolved); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      ex_valid     = $urandom_range(0, 1);
      ex_flags_set = $urandom_range(0, 1);
      ex_flags     = 3'($urandom);
      ex_opcode    = 3'($urandom);
      ex_hold      = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      br_valid     = ($urandom_range(0, 2) != 0);
      br_cond      = 3'($urandom);
      #1;
      n_checks++;
      if (br_stall !== m_stall()) begin
        n_fail++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, br_stall, m_stall());
      end
      tick();
      n_checks++;
      if (flags_q !== m_flags || br_resolved !== m_res || br_taken !== m_taken ||
          stall_cnt !== 16'(m_stall_cnt) || taken_cnt !== 16'(m_taken_cnt)) begin
        n_fail++;
        $display("FAIL rnd_state[%0d] got f=%b r=%b t=%b sc=%0d tc=%0d exp f=%b r=%b t=%b sc=%0d tc=%0d",
                 i, flags_q, br_resolved, br_taken, stall_cnt, taken_cnt,
                 m_flags, m_res, m_taken, m_stall_cnt, m_taken_cnt);
      end
    end
    rst_n = 1;
  endtask

  task automatic test_saturation();
    do_reset();
    ex_valid = 1; ex_flags_set = 1; ex_hold = 1; br_valid = 1;
    for (int i = 0; i < 70000; i++) tick();
    n_checks++;
    if (stall_cnt !== 16'hFFFF || m_stall_cnt != 65535) begin
      n_fail++; $display("FAIL stall_sat got=%h exp=ffff", stall_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    m_flags = 0; m_pending = 0; m_res = 0; m_taken = 0; m_stall_cnt = 0; m_taken_cnt = 0;
    @(posedge clk); #1;
    test_reset();
    test_zero_flag();
    test_back_to_back();
    test_partial_and_blocked();
    test_hold();
    test_flush_wait();
    test_reset_wait();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 ex_valid  in  1  EX stage holds a valid ALU instruction this cycle.
REQ-005 ex_flags  in  3  ALU flags: bit2 V, bit1 N, bit0 Z.
REQ-006 ex_flags_set  in  1  ALU indicates the EX opcode writes flags.
REQ-007 ex_opcode  in  3  EX ALU opcode (000 ADD … 111 PADDSB).
REQ-008 ex_hold  in  1  EX instruction held; it presents again next cycle.
REQ-009 flush  in  1  squash the EX instruction and any pending branch.
REQ-010 br_valid  in  1  decode holds a conditional branch; held high while br_stall=1.
REQ-011 br_cond  in  3  branch condition code.
REQ-012 flags_q  out  3  architectural flag register {V,N,Z}.
REQ-013 br_stall  out  1  combinational; decode must hold the branch this cycle.
REQ-014 br_resolved  out  1  registered; one-cycle pulse when a branch is evaluated.
REQ-015 br_taken  out  1  registered; valid only when br_resolved=1, else 0.
REQ-016 stall_cnt  out  16  saturating count of br_stall cycles.
REQ-017 taken_cnt  out  16  saturating count of taken branches.

Function
REQ-018 Flag write-enable: we = ex_valid & ex_flags_set & ~ex_hold & ~flush.
REQ-019 On we, ADD/SUB (000/001) SHALL update V, N and Z.
REQ-020 On we, XOR/SLL/SRA/ROR (010/100/101/110) SHALL update Z only; V and N SHALL hold.
REQ-021 RED/PADDSB (011/111) SHALL never update flags, even if ex_flags_set=1.
REQ-022 Condition codes: 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GE Z=1|N=0; 101 LE N=1|Z=1; 110 OV V=1; 111 always taken.
REQ-023 The FSM SHALL have two states: IDLE and WAIT.
REQ-024 In IDLE, hazard = br_valid & ex_valid & ex_flags_set & ~flush.
REQ-025 In IDLE with hazard, br_stall SHALL be 1 and the next state SHALL be WAIT.
REQ-026 In IDLE with br_valid, no hazard and no flush, the unit SHALL evaluate br_cond against the current flags_q.
REQ-027 The registered result of that evaluation SHALL appear next cycle as br_resolved=1 with br_taken.
REQ-028 In WAIT, br_stall SHALL be 0 and the unit SHALL evaluate against the updated flags_q.
REQ-029 In WAIT, br_resolved SHALL pulse the following cycle and the next state SHALL be IDLE.
REQ-030 WAIT SHALL ignore new hazards; a branch stalls at most one cycle per hazard.
REQ-031 With ex_hold=1 during a hazard, the FSM SHALL remain in IDLE with br_stall=1 until the EX instruction leaves EX.
REQ-032 On flush in any state: no evaluation, br_resolved=0 next cycle, next state IDLE, flags not written that cycle.
REQ-033 stall_cnt SHALL increment on every cycle with br_stall=1 and saturate at 16'hFFFF.
REQ-034 taken_cnt SHALL increment on every resolution with br_taken=1 and saturate at 16'hFFFF.
REQ-035 Branch-to-resolution latency SHALL be 1 cycle without a hazard and 2 cycles with a hazard.

Reset
REQ-036 On a clk edge with rst_n=0, all outputs and state SHALL reset: flags_q=3'b000, state=IDLE, br_resolved=0, br_taken=0, stall_cnt=0, taken_cnt=0.
REQ-037 Reset SHALL override flush, hold and br_valid.
REQ-038 Reset mid-WAIT SHALL drop the pending branch with no br_resolved pulse.
REQ-039 br_stall SHALL be 0 while rst_n=0.

Verification
REQ-040 Zero flag via SUB: ADD/SUB write {V,N,Z}=001, then BEQ (001) with no EX instruction -> br_resolved=1, br_taken=1 one cycle later; taken_cnt=1.
REQ-041 Back-to-back hazard: flags_q=000; SUB writes flags 001 in cycle T while BEQ is in decode -> br_stall=1 at T only, br_taken=1 at T+2, stall_cnt=1.
REQ-042 Partial update: ADD writes flags 110, then XOR writes Z=1 -> flags_q=111.
REQ-043 Blocked update: PADDSB with ex_flags_set=1 and flags 101 -> flags_q unchanged.
REQ-044 Flush in WAIT: flush=1 in WAIT -> br_resolved=0 next cycle, state IDLE.
REQ-045 Counter saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF.
REQ-046 Reset: rst_n=0 in WAIT with flags 111 -> flags_q=000 and no br_resolved pulse.
